// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Brief    : Shared definitions for the multi-cycle RV32I sequencer:
//            state encoding (3-bit), opcode constants, trap cause codes and
//            the opcode classification helper.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // Coarse instruction classes; everything the sequencer needs to know
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    // RV32I major opcodes
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    // Trap cause codes
    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_imem    = 2'b10;
    localparam logic [1:0] c_cause_dmem    = 2'b11;

    // Map a 7-bit opcode onto the class that decides the state path
    function automatic op_class_t classify(input logic [6:0] op);
        op_class_t cls;
        case (op)
            c_op_r, c_op_i, c_op_auipc, c_op_lui: cls = CLS_ALU;
            c_op_load:                            cls = CLS_LOAD;
            c_op_store:                           cls = CLS_STORE;
            c_op_branch:                          cls = CLS_BRANCH;
            c_op_jal, c_op_jalr:                  cls = CLS_JUMP;
            default:                              cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_mem_wait_timer
// Brief    : 8-bit saturating wait counter for memory handshakes. Flags the
//            final allowed wait cycle so the sequencer can trap if ready is
//            still absent.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_last_cycle
);

    // Timer value on the last cycle a request may still see ready
    localparam logic [7:0] c_last = 8'(MEM_TIMEOUT - 1);
    localparam logic [7:0] c_max  = 8'hFF;

    logic [7:0] r_count;

    // Clear on state change, count waiting cycles, hold at the maximum
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= 8'd0;
        end else if (i_count && (r_count != c_max)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_last_cycle = (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle RV32I sequencer (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP).
//            Drives memory requests and IR/PC/RF write enables, stops and
//            starts only at instruction boundaries, reports sticky traps.
//            Optional performance counters: define MULTICYCLE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        branch,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        mem_wEn,
    output logic        ir_wEn,
    output logic        pc_wEn,
    output logic        next_PC_select,
    output logic        wEn,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    state_t    r_state;
    state_t    w_state_nxt;
    op_class_t r_class;
    op_class_t w_class_dec;
    op_class_t w_class;
    logic [1:0] r_trap_cause;
    logic [1:0] w_cause_nxt;
    state_t    w_boundary;

    // Registered Moore decodes of the state being entered
    logic r_imem_req;
    logic r_dmem_req;
    logic r_mem_wen;
    logic r_exec_branch;
    logic r_wb;
    logic r_wb_jump;
    logic r_busy;
    logic r_trap;

    logic w_waiting;
    logic w_timer_last;
    logic w_retire;

    assign w_class_dec = classify(opcode);
    // The decoder opcode is captured at DECODE; later states use the copy
    assign w_class     = (r_state == ST_DECODE) ? w_class_dec : r_class;
    assign w_boundary  = run ? ST_FETCH : ST_IDLE;
    assign w_waiting   = ((r_state == ST_FETCH) && !imem_ready) ||
                         ((r_state == ST_MEM)   && !dmem_ready);

    multicycle_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_state_nxt != r_state),
        .i_count      (w_waiting),
        .o_last_cycle (w_timer_last)
    );

    // Next-state selection; ready is checked before timeout so it wins
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_trap_cause;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    w_state_nxt = ST_DECODE;
                end else if (w_timer_last) begin
                    w_state_nxt = ST_TRAP;
                    w_cause_nxt = c_cause_imem;
                end
            end
            ST_DECODE: begin
                if (w_class_dec == CLS_ILLEGAL) begin
                    w_state_nxt = ST_TRAP;
                    w_cause_nxt = c_cause_illegal;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((r_class == CLS_LOAD) || (r_class == CLS_STORE)) begin
                    w_state_nxt = ST_MEM;
                end else if (r_class == CLS_BRANCH) begin
                    w_state_nxt = w_boundary;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    w_state_nxt = (r_class == CLS_STORE) ? w_boundary : ST_WB;
                end else if (w_timer_last) begin
                    w_state_nxt = ST_TRAP;
                    w_cause_nxt = c_cause_dmem;
                end
            end
            ST_WB: begin
                w_state_nxt = w_boundary;
            end
            ST_TRAP: begin
                w_state_nxt = ST_TRAP;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus registered output decodes of the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_class       <= CLS_ALU;
            r_trap_cause  <= c_cause_none;
            r_imem_req    <= 1'b0;
            r_dmem_req    <= 1'b0;
            r_mem_wen     <= 1'b0;
            r_exec_branch <= 1'b0;
            r_wb          <= 1'b0;
            r_wb_jump     <= 1'b0;
            r_busy        <= 1'b0;
            r_trap        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_trap_cause  <= w_cause_nxt;
            if (r_state == ST_DECODE) r_class <= w_class_dec;
            r_imem_req    <= (w_state_nxt == ST_FETCH);
            r_dmem_req    <= (w_state_nxt == ST_MEM);
            r_mem_wen     <= (w_state_nxt == ST_MEM) && (w_class == CLS_STORE);
            r_exec_branch <= (w_state_nxt == ST_EXEC) && (w_class == CLS_BRANCH);
            r_wb          <= (w_state_nxt == ST_WB);
            r_wb_jump     <= (w_state_nxt == ST_WB) && (w_class == CLS_JUMP);
            r_busy        <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_TRAP);
            r_trap        <= (w_state_nxt == ST_TRAP);
        end
    end

    // Write enables are masked while reset is low so an aborted
    // instruction never commits anything in its final cycle.
    assign w_retire       = rst_n && (r_exec_branch || r_wb || (r_mem_wen && dmem_ready));
    assign imem_req       = r_imem_req;
    assign ir_wEn         = rst_n && r_imem_req && imem_ready;
    assign dmem_req       = r_dmem_req;
    assign mem_wEn        = rst_n && r_mem_wen;
    assign pc_wEn         = w_retire;
    assign next_PC_select = r_wb_jump || (r_exec_branch && branch);
    assign wEn            = rst_n && r_wb;
    assign busy           = r_busy;
    assign trap           = r_trap;
    assign trap_cause     = r_trap_cause;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    // Busy-cycle and retired-instruction counters, wrap naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else begin
            if (r_busy)   r_cycle_cnt   <= r_cycle_cnt + 32'd1;
            if (w_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
